// File: rtl/swc_lost_pck_free_req.sv
// Lost-packet force-free requester: queues dropped head-page addresses and issues one
// force-free request at a time to the deallocator, re-issuing on timeout.
module swc_lost_pck_free_req #(
  parameter int unsigned PAGE_ADDR_BITS = 10,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          drop_i,
  input  logic [PAGE_ADDR_BITS-1:0]     drop_pgaddr_i,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   pending_o,
  output logic                          force_free_o,
  output logic [PAGE_ADDR_BITS-1:0]     pgaddr_free_o,
  input  logic                          force_free_done_i,
  output logic [15:0]                   freed_cnt_o,
  output logic                          overflow_o,
  output logic                          timeout_o
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned TmoW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TmoEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                      state_q, state_d;
  logic [PAGE_ADDR_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]             count_q, count_d;
  logic                        full_q, full_d;
  logic                        ff_q, ff_d;
  logic [PAGE_ADDR_BITS-1:0]   pg_q, pg_d;
  logic [TmoW-1:0]             tmo_q, tmo_d;
  logic [15:0]                 freed_q, freed_d;
  logic                        ovf_q, ovf_d;
  logic                        tout_q, tout_d;
  logic                        push, pop;

  // A drop arriving while full is lost even if a pop happens on the same edge.
  assign push    = drop_i & ~full_q;
  assign ovf_d   = ovf_q | (drop_i & full_q);
  assign count_d = count_q + CntW'(push) - CntW'(pop);
  assign full_d  = (count_d == CntW'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    ff_d    = 1'b0;
    pg_d    = pg_q;
    tmo_d   = tmo_q;
    freed_d = freed_q;
    tout_d  = tout_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d = StReq;
          ff_d    = 1'b1;
          pg_d    = mem_q[rd_ptr_q];
        end
      end
      StReq: begin
        state_d = StWait;
        tmo_d   = '0;
      end
      StWait: begin
        if (force_free_done_i) begin
          pop     = 1'b1;
          freed_d = freed_q + 16'd1;
          state_d = StIdle;
        end else if (TmoEn && (tmo_q == TmoLast)) begin
          tout_d  = 1'b1;
          ff_d    = 1'b1;
          state_d = StReq;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ff_q     <= 1'b0;
      pg_q     <= '0;
      tmo_q    <= '0;
      freed_q  <= '0;
      ovf_q    <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ff_q     <= ff_d;
      pg_q     <= pg_d;
      tmo_q    <= tmo_d;
      freed_q  <= freed_d;
      ovf_q    <= ovf_d;
      tout_q   <= tout_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= drop_pgaddr_i;
  end

  assign full_o        = full_q;
  assign pending_o     = count_q;
  assign force_free_o  = ff_q;
  assign pgaddr_free_o = pg_q;
  assign freed_cnt_o   = freed_q;
  assign overflow_o    = ovf_q;
  assign timeout_o     = tout_q;

endmodule
